pe_seq_controller: RTL
======================

# pe_seq_controller

Parametrised main sequencer for the convolution PE. It is the successor to the fixed two-stage PE controller. It drives the IFMAP/filter scratchpad read pipeline, the multiplier/accumulator, the filter and stride counters, the start-pointer unit and the psum buffer. New over the previous generation:
- configurable pipeline depth with an explicit drain phase;
- psum read-modify-write sequencing;
- a recoverable halt state;
- a start/busy/done handshake.

## Interface
- FILTER_ADDR_WIDTH, 8: width of filter write-count input.
- PIPE_DEPTH, 2: read→result pipeline stages (1..8).
- FILL_W, $clog2(PIPE_DEPTH+1): width of fill_level.

- clk in 1: single clock, rising edge.
- reset_n in 1: asynchronous, active-low reset.
- start in 1: level request; run begins on rising edge.
- if_empty in 1: IFMAP buffer empty.
- filter_wcount in FILTER_ADDR_WIDTH: filter words written.
- sp_valid in 1: start pointer valid.
- reading_empty, filter_cannot_read in 1: read-side stall sources.
- f_co in 1: filter counter carry-out (last tap of window).
- go_next_stride, stride_ended, go_next_filter, is_last_filter in 1: stride/filter status.
- psum_mode in 1: 1 = accumulate into existing psum, 0 = overwrite.
- psum_can_read, psum_rvalid, psum_w_co in 1: psum buffer status; psum_w_co = last psum address written.
- error, resume in 1: error entry, halt exit pulse.
- chip_en, global_rst, en_p_traverse out 1.
- ren, ld_IF, i_en, mult_en, ld_result, en_f_counter, rst_f_counter out 1.
- next_stride, next_filter, rst_stride, next_start, make_empty, rst_if_ctx out 1.
- psum_ren, psum_wen, next_psum_raddr, next_psum_waddr out 1.
- busy, done, halted out 1.
- fill_level out FILL_W: count of valid pipeline stages.

## Operation
- Registers: state, start_q (edge detect), valid[PIPE_DEPTH-1:0], last_flag. All clear on reset.
- Outputs are combinational from the registers and current inputs. All outputs default to 0.
- freeze = reading_empty | filter_cannot_read | ~sp_valid. adv = ~freeze.
- chip_en = 1 in every state except IDLE. busy = chip_en & ~done.
- States and transitions:
  - IDLE → INIT on start & ~start_q.
  - INIT: global_rst = 1. Next state is WAIT_DATA.
  - WAIT_DATA → FIND_SP when ~if_empty & filter_wcount != 0.
  - FIND_SP: en_p_traverse = ~sp_valid. → FILL when sp_valid.
  - FILL: ren = ld_IF = i_en = adv. valid shifts in 1 on adv. → RUN when adv and fill_level == PIPE_DEPTH-1.
  - RUN: run = adv & ~f_co.
    - ren, ld_IF, i_en, en_f_counter, mult_en, ld_result = run.
    - next_stride = run & go_next_stride & ~stride_ended.
    - next_filter = rst_stride = adv & go_next_filter & ~is_last_filter.
    - If adv & go_next_filter & is_last_filter, set last_flag.
    - On f_co & adv → DRAIN.
  - DRAIN: no reads. valid shifts in 0 each cycle, ignoring freeze. mult_en = valid[0]. ld_result = valid[PIPE_DEPTH-1]. → PSUM_RD (psum_mode=1) or PSUM_WR (psum_mode=0) when valid == 0.
  - PSUM_RD: psum_ren = psum_can_read. → PSUM_WR on psum_rvalid.
  - PSUM_WR: psum_wen = 1, next_psum_waddr = 1, next_psum_raddr = psum_mode, rst_f_counter = 1. Exits in priority order:
    - → DONE if psum_w_co;
    - else → NEXT_IF if last_flag;
    - else → FILL.
  - NEXT_IF: rst_if_ctx = make_empty = rst_stride = 1. Clears last_flag. → UPD_SP.
  - UPD_SP: next_start = 1. → FIND_SP.
  - DONE: done = 1. → IDLE when start = 0.
  - HALT: halted = 1. → IDLE on resume.
- Error: when error = 1 in any state other than IDLE or HALT, next state = HALT. This overrides all other transitions. valid and last_flag are cleared on HALT entry.
- fill_level = popcount(valid).

## Timing
- Reset (reset_n low, async): state = IDLE. All outputs 0, fill_level 0.
- Reset mid-run aborts immediately. No psum write is issued.
- Start rising edge at cycle n: INIT at n+1 (global_rst for exactly 1 cycle), WAIT_DATA at n+2.
- Holding start high does not retrigger. A new run requires start to fall, then rise again.
- Fill latency: PIPE_DEPTH advancing cycles. Freeze cycles insert bubbles without losing pipeline state.
- Drain takes exactly PIPE_DEPTH cycles. The first ld_result in DRAIN occurs in the cycle the last valid stage is present.
- Simultaneous f_co and go_next_filter&is_last_filter in RUN: last_flag is set and DRAIN is entered, both in the same cycle.
- psum_w_co and last_flag both set in PSUM_WR: DONE wins.
- error together with start in IDLE is ignored.
- resume outside HALT has no effect.

## Test plan
- Basic run: PIPE_DEPTH=3, psum_mode=0, no freeze, f_co after 9 RUN cycles, psum_w_co on the 1st write → INIT 1 cycle, 3 FILL cycles, 9 RUN cycles with ld_result each cycle, 3 DRAIN cycles, one psum_wen, done high until start falls.
- Freeze: assert reading_empty for 4 cycles mid-FILL at fill_level=1 → ren/ld_IF low for those cycles, fill_level holds at 1, RUN is entered 4 cycles later than in the basic run.
- Accumulate mode: psum_mode=1, psum_can_read low 2 cycles then high, psum_rvalid 1 cycle later → psum_ren only when can_read is high, then psum_wen, next_psum_raddr and next_psum_waddr pulse together once.
- Last filter: go_next_filter&is_last_filter in RUN, then f_co → next_filter not pulsed, NEXT_IF (rst_if_ctx, make_empty, rst_stride) then UPD_SP (next_start), then FIND_SP.
- Error/halt: error pulse in DRAIN → HALT next cycle, halted=1, fill_level=0. resume → IDLE. A new start edge → INIT.
- Async reset mid-RUN (PIPE_DEPTH=8): all outputs 0 within the same cycle. start held high through reset release does not start a run until start falls and rises again.

Source files
------------

// File: rtl/pe_seq_controller.sv
// pe_seq_controller: convolution PE main sequencer with configurable read pipeline, drain phase,
// psum read-modify-write, recoverable halt and start/busy/done handshake.
module pe_seq_controller #(
  parameter int FILTER_ADDR_WIDTH = 8,
  parameter int PIPE_DEPTH        = 2,
  parameter int FILL_W            = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         if_empty,
  input  logic [FILTER_ADDR_WIDTH-1:0] filter_wcount,
  input  logic                         sp_valid,
  input  logic                         reading_empty,
  input  logic                         filter_cannot_read,
  input  logic                         f_co,
  input  logic                         go_next_stride,
  input  logic                         stride_ended,
  input  logic                         go_next_filter,
  input  logic                         is_last_filter,
  input  logic                         psum_mode,
  input  logic                         psum_can_read,
  input  logic                         psum_rvalid,
  input  logic                         psum_w_co,
  input  logic                         error,
  input  logic                         resume,
  output logic                         chip_en,
  output logic                         global_rst,
  output logic                         en_p_traverse,
  output logic                         ren,
  output logic                         ld_IF,
  output logic                         i_en,
  output logic                         mult_en,
  output logic                         ld_result,
  output logic                         en_f_counter,
  output logic                         rst_f_counter,
  output logic                         next_stride,
  output logic                         next_filter,
  output logic                         rst_stride,
  output logic                         next_start,
  output logic                         make_empty,
  output logic                         rst_if_ctx,
  output logic                         psum_ren,
  output logic                         psum_wen,
  output logic                         next_psum_raddr,
  output logic                         next_psum_waddr,
  output logic                         busy,
  output logic                         done,
  output logic                         halted,
  output logic [FILL_W-1:0]            fill_level
);
  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_DATA, FIND_SP, FILL, RUN, DRAIN,
    PSUM_RD, PSUM_WR, NEXT_IF, UPD_SP, DONE, HALT
  } state_t;
  state_t                state_q, state_d;
  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  start_lo_q;
  logic                  adv, run;
  assign adv = ~(reading_empty | filter_cannot_read | ~sp_valid);
  assign run = (state_q == RUN) & adv & ~f_co;
  always_comb begin
    fill_level = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) fill_level = fill_level + FILL_W'(valid_q[i]);
  end
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE:      if (start & start_lo_q) state_d = INIT;
      INIT:      begin state_d = WAIT_DATA; last_d = 1'b0; end
      WAIT_DATA: if (~if_empty && filter_wcount != '0) state_d = FIND_SP;
      FIND_SP:   if (sp_valid) state_d = FILL;
      FILL: if (adv) begin
        valid_d = (valid_q << 1) | PIPE_DEPTH'(1);
        if (fill_level == FILL_W'(PIPE_DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (adv & go_next_filter & is_last_filter) last_d = 1'b1;
        if (adv & f_co) state_d = DRAIN;
      end
      // Exit on the shifted value so the drain lasts exactly PIPE_DEPTH cycles.
      DRAIN: begin
        valid_d = valid_q << 1;
        if (valid_d == '0) state_d = psum_mode ? PSUM_RD : PSUM_WR;
      end
      PSUM_RD:   if (psum_rvalid) state_d = PSUM_WR;
      PSUM_WR:   state_d = psum_w_co ? DONE : last_q ? NEXT_IF : FILL;
      NEXT_IF:   begin state_d = UPD_SP; last_d = 1'b0; end
      UPD_SP:    state_d = FIND_SP;
      DONE:      if (~start) state_d = IDLE;
      HALT:      if (resume) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (error && state_q != IDLE && state_q != HALT) begin
      state_d = HALT;
      valid_d = '0;
      last_d  = 1'b0;
    end
  end
  // start_lo_q clears on reset, so a start held high across reset release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      last_q     <= 1'b0;
      start_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      start_lo_q <= ~start;
    end
  end
  assign chip_en         = state_q != IDLE;
  assign done            = state_q == DONE;
  assign busy            = chip_en & ~done;
  assign halted          = state_q == HALT;
  assign global_rst      = state_q == INIT;
  assign en_p_traverse   = (state_q == FIND_SP) & ~sp_valid;
  assign ren             = ((state_q == FILL) & adv) | run;
  assign ld_IF           = ren;
  assign i_en            = ren;
  assign en_f_counter    = run;
  assign mult_en         = run | ((state_q == DRAIN) & valid_q[0]);
  assign ld_result       = run | ((state_q == DRAIN) & valid_q[PIPE_DEPTH-1]);
  assign next_stride     = run & go_next_stride & ~stride_ended;
  assign next_filter     = (state_q == RUN) & adv & go_next_filter & ~is_last_filter;
  assign rst_stride      = next_filter | (state_q == NEXT_IF);
  assign make_empty      = state_q == NEXT_IF;
  assign rst_if_ctx      = state_q == NEXT_IF;
  assign next_start      = state_q == UPD_SP;
  assign psum_ren        = (state_q == PSUM_RD) & psum_can_read;
  assign psum_wen        = state_q == PSUM_WR;
  assign next_psum_waddr = psum_wen;
  assign next_psum_raddr = psum_wen & psum_mode;
  assign rst_f_counter   = psum_wen;
endmodule
